// File: rtl/alu_mbyte_seq.sv
// alu_mbyte_seq: drives an external 8-bit registered ALU through NBYTES-wide PASS/ADD/AND/XOR, LSB first.
// Define ALU_MBYTE_SEQ_SUB_EN to enable cmd 100 = SUB (A + ~B + 1); without it every cmd 1xx is rejected.
module alu_mbyte_seq #(
  parameter int NBYTES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [2:0]          cmd,
  input  logic                cin,
  input  logic [8*NBYTES-1:0] opa,
  input  logic [8*NBYTES-1:0] opb,
  input  logic                hold,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [8*NBYTES-1:0] result,
  output logic                cout,
  output logic [2:0]          alu_op,
  output logic [7:0]          alu_a,
  output logic [7:0]          alu_b,
  output logic                alu_hazard,
  input  logic [7:0]          alu_res,
  input  logic                alu_ovf
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_CAPT   = 3'd2,
    S_CISSUE = 3'd3,
    S_CCAPT  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t state_reg, state_next;

  logic [W-1:0]  a_reg, b_reg, r_reg, r_next, result_reg;
  logic [IW-1:0] idx_reg, idx_next;
  logic          carry_reg, carry_next;
  logic          c1_reg, add_reg, rej_reg, cout_reg;
  logic [2:0]    op_reg;
  logic          is_sub, cmd_ok, cmd_add, start_carry;
  logic [2:0]    cmd_op;
  logic          last_byte, capture_last;

  logic [7:0] a_byte [NBYTES];
  logic [7:0] b_byte [NBYTES];
  logic [7:0] r_byte [NBYTES];

  genvar gi;
  generate
    for (gi = 0; gi < NBYTES; gi++) begin : g_lane
      assign a_byte[gi] = a_reg[8*gi +: 8];
      assign b_byte[gi] = b_reg[8*gi +: 8];
      assign r_byte[gi] = r_reg[8*gi +: 8];
    end
  endgenerate

`ifdef ALU_MBYTE_SEQ_SUB_EN
  assign is_sub = (cmd == 3'b100);
`else
  assign is_sub = 1'b0;
`endif

  assign cmd_ok      = ~cmd[2] | is_sub;
  assign cmd_add     = (cmd == 3'b001) | is_sub;
  assign cmd_op      = is_sub ? 3'b001 : {1'b0, cmd[1:0]};
  // SUB is A + ~B + 1, so its chain starts with a forced carry.
  assign start_carry = is_sub | ((cmd == 3'b001) & cin);

  assign last_byte    = (idx_reg == LAST_IDX);
  assign capture_last = ((state_reg == S_CAPT) || (state_reg == S_CCAPT)) && (state_next == S_DONE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; hold freezes the sequencer in place
  always_comb begin
    state_next = state_reg;
    if (!hold) begin
      case (state_reg)
        S_IDLE:   if (start) state_next = cmd_ok ? S_ISSUE : S_DONE;
        S_ISSUE:  state_next = S_CAPT;
        S_CAPT: begin
          if (add_reg && carry_reg) state_next = S_CISSUE;
          else                      state_next = last_byte ? S_DONE : S_ISSUE;
        end
        S_CISSUE: state_next = S_CCAPT;
        S_CCAPT:  state_next = last_byte ? S_DONE : S_ISSUE;
        S_DONE:   state_next = S_IDLE;
        default:  state_next = S_IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    alu_op = 3'b000;
    alu_a  = 8'h00;
    alu_b  = 8'h00;
    busy   = 1'b0;
    done   = 1'b0;
    case (state_reg)
      S_ISSUE: begin
        busy   = 1'b1;
        alu_op = op_reg;
        alu_a  = a_byte[idx_reg];
        alu_b  = b_byte[idx_reg];
      end
      S_CAPT, S_CCAPT: busy = 1'b1;
      S_CISSUE: begin
        busy   = 1'b1;
        alu_op = 3'b001;
        alu_a  = r_byte[idx_reg];
        alu_b  = 8'h01;
      end
      S_DONE: begin
        done = 1'b1;
        // A rejected command is only ever seen as this single cycle
        busy = rej_reg;
      end
      default: ;
    endcase
  end

  // Datapath next values: byte capture, carry chain and byte index
  always_comb begin
    r_next     = r_reg;
    carry_next = carry_reg;
    idx_next   = idx_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          idx_next   = '0;
          carry_next = start_carry;
        end
      end
      S_CAPT: begin
        r_next[{idx_reg, 3'b000} +: 8] = alu_res;
        if (!(add_reg && carry_reg)) begin
          carry_next = add_reg & alu_ovf;
          if (!last_byte) idx_next = idx_reg + 1'b1;
        end
      end
      S_CCAPT: begin
        // A byte sum and its +1 pass can never both overflow, so OR is the true carry
        r_next[{idx_reg, 3'b000} +: 8] = alu_res;
        carry_next = c1_reg | alu_ovf;
        if (!last_byte) idx_next = idx_reg + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg      <= '0;
      b_reg      <= '0;
      r_reg      <= '0;
      idx_reg    <= '0;
      carry_reg  <= 1'b0;
      c1_reg     <= 1'b0;
      add_reg    <= 1'b0;
      rej_reg    <= 1'b0;
      op_reg     <= 3'b000;
      result_reg <= '0;
      cout_reg   <= 1'b0;
    end else if (!hold) begin
      r_reg     <= r_next;
      idx_reg   <= idx_next;
      carry_reg <= carry_next;
      if ((state_reg == S_IDLE) && start) begin
        a_reg   <= opa;
        b_reg   <= is_sub ? ~opb : opb;
        op_reg  <= cmd_op;
        add_reg <= cmd_add;
        rej_reg <= ~cmd_ok;
      end
      // Overflow is only trusted in the cycle after an issued op 001
      if (state_reg == S_CAPT) c1_reg <= add_reg & alu_ovf;
      if (capture_last) begin
        result_reg <= r_next;
        cout_reg   <= add_reg & carry_next;
      end
    end
  end

  assign result     = result_reg;
  assign cout       = cout_reg;
  assign err        = done & rej_reg;
  assign alu_hazard = hold & rst_n;

endmodule

// File: tb/tb_alu_mbyte_seq.sv
// Bench for alu_mbyte_seq with an 8-bit registered ALU model and a whole-word arithmetic reference.
// Honours ALU_MBYTE_SEQ_SUB_EN the same way the design does.
module tb_alu_mbyte_seq;
  localparam int N = 2;
  localparam int W = 8 * N;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         cin = 1'b0;
  logic         hold = 1'b0;
  logic [2:0]   cmd = 3'b000;
  logic [W-1:0] opa = '0;
  logic [W-1:0] opb = '0;
  logic         busy, done, err, cout, alu_hazard;
  logic [W-1:0] result;
  logic [2:0]   alu_op;
  logic [7:0]   alu_a, alu_b;
  logic [7:0]   alu_res;
  logic         alu_ovf;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Request fields, written by the driver only
  int           issue_id = 0;
  int           req_start_cyc = 0;
  int           req_lat = 0;
  logic [W-1:0] req_res = '0, req_a = '0, req_b = '0;
  logic         req_co = 1'b0;
  bit           req_rej = 1'b0;
  logic [2:0]   req_cmd = 3'b000, req_op = 3'b000;
  logic [7:0]   req_a0 = 8'h00, req_b0 = 8'h00;
  bit           req_lit = 1'b0;
  logic [W-1:0] lit_res = '0;
  logic         lit_co = 1'b0;
  int           lit_lat = 0;

  // Tracking state, written by the compare process only
  int           seen_id = 0;
  int           done_id = 0;
  int           done_cyc = 0;
  logic [W-1:0] stable_res = '0;
  logic         stable_co = 1'b0;

  alu_mbyte_seq #(.NBYTES(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cmd(cmd), .cin(cin),
    .opa(opa), .opb(opb), .hold(hold), .busy(busy), .done(done), .err(err),
    .result(result), .cout(cout), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_hazard(alu_hazard), .alu_res(alu_res), .alu_ovf(alu_ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Registered ALU: latches op/operands every edge unless data_hazard is high
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_res <= 8'h00;
      alu_ovf <= 1'b0;
    end else if (!alu_hazard) begin
      case (alu_op)
        3'b000:  begin alu_res <= alu_a;         alu_ovf <= 1'b0; end
        3'b001:  {alu_ovf, alu_res} <= {1'b0, alu_a} + {1'b0, alu_b};
        3'b010:  begin alu_res <= alu_a & alu_b; alu_ovf <= 1'b0; end
        3'b011:  begin alu_res <= alu_a ^ alu_b; alu_ovf <= 1'b0; end
        default: begin alu_res <= 8'h00;         alu_ovf <= 1'b0; end
      endcase
    end
  end

  // Whole-word reference: result, carry-out, latency and first ALU issue
  function automatic void model(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic ci, output logic [W-1:0] r, output logic co,
                                output int lat, output bit rej, output logic [2:0] op,
                                output logic [7:0] b0);
    logic [W:0]   sum, m;
    logic [W-1:0] bb;
    logic         cc;
    bit           is_add;
    int           carries;
    rej = 1'b0; is_add = 1'b0; bb = b; cc = ci; op = 3'b000; r = '0; co = 1'b0; carries = 0;
    case (c)
      3'b000: r = a;
      3'b001: begin is_add = 1'b1; op = 3'b001; end
      3'b010: begin r = a & b; op = 3'b010; end
      3'b011: begin r = a ^ b; op = 3'b011; end
`ifdef ALU_MBYTE_SEQ_SUB_EN
      3'b100: begin is_add = 1'b1; bb = ~b; cc = 1'b1; op = 3'b001; end
`endif
      default: rej = 1'b1;
    endcase
    if (is_add) begin
      sum = {1'b0, a} + {1'b0, bb} + (W+1)'(cc);
      r = sum[W-1:0];
      co = sum[W];
      // a byte costs an extra +1 pass whenever a carry flows into it
      for (int i = 0; i < N; i++) begin
        m = '0;
        for (int k = 0; k < 8*i; k++) m[k] = 1'b1;
        sum = ({1'b0, a} & m) + ({1'b0, bb} & m) + (W+1)'(cc);
        if (sum[8*i]) carries++;
      end
    end
    lat = rej ? 1 : 2*N + 1 + 2*carries;
    b0 = bb[7:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (issue_id != seen_id) begin
      seen_id  = issue_id;
      done_cyc = req_start_cyc + req_lat - 1;
    end
    check("alu_hazard", 64'(alu_hazard), 64'(hold & rst_n));
    if (!rst_n) begin
      check("rst_busy",   64'(busy),   64'(1'b0));
      check("rst_done",   64'(done),   64'(1'b0));
      check("rst_err",    64'(err),    64'(1'b0));
      check("rst_cout",   64'(cout),   64'(1'b0));
      check("rst_result", 64'(result), 64'(0));
      check("rst_alu_op", 64'(alu_op), 64'(0));
      check("rst_alu_a",  64'(alu_a),  64'(0));
      check("rst_alu_b",  64'(alu_b),  64'(0));
      done_id    = seen_id;
      stable_res = '0;
      stable_co  = 1'b0;
    end else if (seen_id != done_id) begin
      if (hold && cyc < done_cyc) done_cyc++;
      if (cyc == req_start_cyc && !req_rej) begin
        check("issue_alu_op", 64'(alu_op), 64'(req_op));
        check("issue_alu_a",  64'(alu_a),  64'(req_a0));
        check("issue_alu_b",  64'(alu_b),  64'(req_b0));
      end
      if (cyc == done_cyc) begin
        check("done", 64'(done), 64'(1'b1));
        check("err",  64'(err),  64'(req_rej));
        if (req_rej) begin
          check("rej_result", 64'(result), 64'(stable_res));
          check("rej_cout",   64'(cout),   64'(stable_co));
        end else begin
          check("result",    64'(result), 64'(req_res));
          check("cout",      64'(cout),   64'(req_co));
          check("done_busy", 64'(busy),   64'(1'b0));
          stable_res = req_res;
          stable_co  = req_co;
        end
        if (req_lit) begin
          check("lit_result",  64'(result), 64'(lit_res));
          check("lit_cout",    64'(cout),   64'(lit_co));
          check("lit_latency", 64'(cyc - req_start_cyc + 1), 64'(lit_lat));
          check("lit_model",   64'(req_lat + (done_cyc - (req_start_cyc + req_lat - 1))), 64'(lit_lat));
        end
        $display("txn %0d cmd=%0d a=%h b=%h result=%h cout=%0d err=%0d latency=%0d",
                 seen_id, req_cmd, req_a, req_b, result, cout, err, cyc - req_start_cyc + 1);
        done_id = seen_id;
      end else begin
        check("busy_done",    64'(done),   64'(1'b0));
        check("busy",         64'(busy),   64'(1'b1));
        check("busy_result",  64'(result), 64'(stable_res));
      end
    end else begin
      check("idle_done",   64'(done),   64'(1'b0));
      check("idle_busy",   64'(busy),   64'(1'b0));
      check("idle_err",    64'(err),    64'(1'b0));
      check("idle_result", 64'(result), 64'(stable_res));
      check("idle_cout",   64'(cout),   64'(stable_co));
    end
  end

  // Called at #1 after a rising edge with the design idle; returns the same way
  task automatic run_cmd(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ci, input int hoff_in, input int hlen_in, input int rst_at,
                         input bit noise, input bit lit, input logic [W-1:0] lres,
                         input logic lco, input int llat);
    logic [W-1:0] r;
    logic         co;
    int           lat, hoff, hlen;
    bit           rej;
    logic [2:0]   op;
    logic [7:0]   b0;
    model(c, a, b, ci, r, co, lat, rej, op, b0);
    hoff = hoff_in;
    hlen = hlen_in;
    if (lat < 2) hlen = 0;
    else if (hoff > lat - 2) hoff = hoff % (lat - 1);
    cmd = c; opa = a; opb = b; cin = ci; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    opa = W'($urandom); opb = W'($urandom); cin = 1'($urandom); cmd = 3'($urandom);
    req_res = r; req_co = co; req_lat = lat; req_rej = rej; req_op = op;
    req_a0 = a[7:0]; req_b0 = b0; req_cmd = c; req_a = a; req_b = b;
    req_lit = lit; lit_res = lres; lit_co = lco; lit_lat = llat;
    req_start_cyc = cyc;
    issue_id++;
    for (int k = 0; ; k++) begin
      if (k > 400) begin
        $display("FAIL timeout waiting for done on txn %0d", issue_id);
        $fatal(1);
      end
      if (done_id == issue_id) break;
      hold = (hlen > 0) && (k >= hoff) && (k < hoff + hlen);
      if (rst_at == k) rst_n = 1'b0;
      // start while busy must be ignored
      start = noise && ($urandom_range(0, 3) == 0);
      if (start) begin
        cmd = 3'($urandom); opa = W'($urandom); opb = W'($urandom);
      end
      @(posedge clk); #1;
    end
    hold = 1'b0;
    start = 1'b0;
    rst_n = 1'b1;
  endtask

  function automatic logic [W-1:0] rnd_op();
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) begin
      case ($urandom_range(0, 4))
        0:       v[8*i +: 8] = 8'hFF;
        1:       v[8*i +: 8] = 8'h00;
        2:       v[8*i +: 8] = 8'h01;
        default: v[8*i +: 8] = 8'($urandom);
      endcase
    end
    return v;
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    run_cmd(3'b001, 16'h00FF, 16'h0001, 1'b0, 0, 0, -1, 1'b0, 1'b1, 16'h0100, 1'b0, 7);
    run_cmd(3'b001, 16'hFFFF, 16'h0001, 1'b0, 0, 0, -1, 1'b0, 1'b1, 16'h0000, 1'b1, 7);
    run_cmd(3'b001, 16'h1234, 16'h1111, 1'b0, 0, 0, -1, 1'b0, 1'b1, 16'h2345, 1'b0, 5);
    run_cmd(3'b011, 16'hF0F0, 16'hFF00, 1'b0, 0, 0, -1, 1'b0, 1'b1, 16'h0FF0, 1'b0, 5);
    run_cmd(3'b010, 16'hF0F0, 16'hFF00, 1'b0, 0, 0, -1, 1'b0, 1'b1, 16'hF000, 1'b0, 5);
    run_cmd(3'b001, 16'h00FF, 16'h0001, 1'b0, 5, 3, -1, 1'b0, 1'b1, 16'h0100, 1'b0, 10);
`ifdef ALU_MBYTE_SEQ_SUB_EN
    run_cmd(3'b100, 16'h0100, 16'h0001, 1'b0, 0, 0, -1, 1'b0, 1'b1, 16'h00FF, 1'b1, 7);
`else
    run_cmd(3'b100, 16'h0100, 16'h0001, 1'b0, 0, 0, -1, 1'b0, 1'b1, 16'h0100, 1'b0, 1);
`endif
    // Reset asserted during the CISSUE of byte 1
    run_cmd(3'b001, 16'h00FF, 16'h0001, 1'b0, 0, 0, 4, 1'b0, 1'b0, '0, 1'b0, 0);
    run_cmd(3'b001, 16'h0001, 16'h0001, 1'b0, 0, 0, -1, 1'b0, 1'b1, 16'h0002, 1'b0, 5);

    for (int t = 0; t < 60; t++) begin
      run_cmd(3'($urandom_range(0, 7)), rnd_op(), rnd_op(), 1'($urandom),
              $urandom_range(0, 12),
              ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0,
              -1, 1'b1, 1'b0, '0, 1'b0, 0);
      if ($urandom_range(0, 3) == 0) begin
        hold = 1'b1;
        @(posedge clk); #1;
        hold = 1'b0;
      end
    end

    repeat (2) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
